// File: rtl/sum_ip_v2_acc_if.sv
// AXI4-Lite slave bus bundle for sum_ip_v2_acc.
// Signal names follow the AXI4-Lite S_AXI_* naming used by the PS interconnect.
//   slave  : seen by the accumulator (drives READY/VALID responses, B/R payload)
//   master : seen by whatever drives transactions (interconnect or testbench)
interface sum_ip_v2_acc_if #(
  parameter int AW = 6
);
  logic [AW-1:0] S_AXI_AWADDR;
  logic          S_AXI_AWVALID;
  logic          S_AXI_AWREADY;
  logic [31:0]   S_AXI_WDATA;
  logic [3:0]    S_AXI_WSTRB;
  logic          S_AXI_WVALID;
  logic          S_AXI_WREADY;
  logic [1:0]    S_AXI_BRESP;
  logic          S_AXI_BVALID;
  logic          S_AXI_BREADY;
  logic [AW-1:0] S_AXI_ARADDR;
  logic          S_AXI_ARVALID;
  logic          S_AXI_ARREADY;
  logic [31:0]   S_AXI_RDATA;
  logic [1:0]    S_AXI_RRESP;
  logic          S_AXI_RVALID;
  logic          S_AXI_RREADY;

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
           S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
    output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
           S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );

  modport master (
    output S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
           S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
    input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
           S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );
endinterface

// File: rtl/sum_ip_v2_acc.sv
// sum_ip_v2_acc: AXI4-Lite memory-mapped accumulator.
// Software loads NUM_OPS operands, writes START, and the block adds one
// operand per cycle into an OP_WIDTH+4 accumulator, then publishes RESULT
// (wrapped or saturated), sticky DONE/OVF and a one-cycle done_irq.
// Ports:
//   ACLK      clock
//   ARESET    synchronous reset, active high
//   s_axi     AXI4-Lite slave bundle (AW/W/B/AR/R channels)
//   done_irq  one-cycle pulse when a sum completes
// Map: 0x00 CTRL (b0 START, b1 CLR, reads 0), 0x04 STATUS {OVF,DONE,BUSY},
//      0x08 RESULT, 0x0C+4*i OP[i].
module sum_ip_v2_acc #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6,
  parameter int NUM_OPS            = 4,
  parameter int OP_WIDTH           = 32,
  parameter bit SATURATE           = 1'b0
) (
  input  logic          ACLK,
  input  logic          ARESET,
  sum_ip_v2_acc_if.slave s_axi,
  output logic          done_irq
);
  localparam int AW   = C_S_AXI_ADDR_WIDTH;
  localparam int DW   = C_S_AXI_DATA_WIDTH;
  localparam int SW   = DW / 8;
  localparam int KW   = $clog2(NUM_OPS);
  localparam int ACCW = OP_WIDTH + 4;   // 4 guard bits hold up to 16 full-scale operands

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_DONE} state_t;
  state_t state_q, state_d;

  logic [OP_WIDTH-1:0] op_q [NUM_OPS];
  logic [ACCW-1:0]     acc_q;
  logic [KW-1:0]       k_q;
  logic [OP_WIDTH-1:0] result_q;
  logic                done_q, ovf_q, irq_q;

  logic          awready_q, bvalid_q, arready_q, rvalid_q;
  logic [1:0]    bresp_q;
  logic [DW-1:0] rdata_q;

  // ---------------- write decode ----------------
  logic [31:0]   wword, rword;
  logic          busy, wr_fire, w_ctrl, w_op, wr_err, start_go, clr_go, op_we;
  logic [KW-1:0] w_sel, r_sel;
  logic [DW-1:0] w_old, w_merge, rd_word;

  assign wword = 32'(s_axi.S_AXI_AWADDR[AW-1:2]);
  assign rword = 32'(s_axi.S_AXI_ARADDR[AW-1:2]);

  always_comb begin
    busy     = (state_q != S_IDLE);
    wr_fire  = awready_q && s_axi.S_AXI_AWVALID && s_axi.S_AXI_WVALID;
    w_ctrl   = (wword == 32'd0);
    w_op     = (wword >= 32'd3) && (wword < 32'(NUM_OPS + 3));
    w_sel    = KW'(wword - 32'd3);
    // Only operand writes and START are fenced while summing; CLR still lands.
    wr_err   = busy && (w_op || (w_ctrl && s_axi.S_AXI_WDATA[0]));
    start_go = wr_fire && w_ctrl && s_axi.S_AXI_WDATA[0] && !busy;
    clr_go   = wr_fire && w_ctrl && s_axi.S_AXI_WDATA[1] && !wr_err;
    op_we    = wr_fire && w_op && !busy;
    w_old    = w_op ? DW'(op_q[w_sel]) : '0;
    w_merge  = w_old;
    for (int b = 0; b < SW; b++)
      if (s_axi.S_AXI_WSTRB[b]) w_merge[b*8 +: 8] = s_axi.S_AXI_WDATA[b*8 +: 8];
  end

  // ---------------- read mux ----------------
  always_comb begin
    r_sel   = KW'(rword - 32'd3);
    rd_word = '0;
    if (rword == 32'd1)      rd_word = DW'({ovf_q, done_q, busy});
    else if (rword == 32'd2) rd_word = DW'(result_q);
    else if (rword >= 32'd3 && rword < 32'(NUM_OPS + 3)) rd_word = DW'(op_q[r_sel]);
  end

  // ---------------- AXI channel handshakes ----------------
  // READY is registered and self-clears, giving a single-cycle accept pulse.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      awready_q <= s_axi.S_AXI_AWVALID && s_axi.S_AXI_WVALID && !bvalid_q && !awready_q;
      if (wr_fire) begin
        bvalid_q <= 1'b1;
        bresp_q  <= wr_err ? 2'b10 : 2'b00;
      end else if (s_axi.S_AXI_BREADY) begin
        bvalid_q <= 1'b0;
      end
      arready_q <= s_axi.S_AXI_ARVALID && !rvalid_q && !arready_q;
      if (arready_q && s_axi.S_AXI_ARVALID) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_word;
      end else if (s_axi.S_AXI_RREADY) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  // ---------------- operand registers ----------------
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      for (int i = 0; i < NUM_OPS; i++) op_q[i] <= '0;
    end else if (op_we) begin
      for (int i = 0; i < NUM_OPS; i++)
        if (w_sel == KW'(i)) op_q[i] <= w_merge[OP_WIDTH-1:0];
    end
  end

  // ---------------- FSM ----------------
  always_ff @(posedge ACLK) begin
    if (ARESET) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_go) state_d = S_ACC;
      S_ACC:   if (k_q == KW'(NUM_OPS - 1)) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------- datapath / status ----------------
  logic acc_hi;
  assign acc_hi = |acc_q[ACCW-1:OP_WIDTH];

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      acc_q    <= '0;
      k_q      <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      irq_q <= 1'b0;
      if (clr_go) begin
        done_q <= 1'b0;
        ovf_q  <= 1'b0;
      end
      case (state_q)
        S_IDLE: if (start_go) begin
          acc_q  <= '0;
          k_q    <= '0;
          done_q <= 1'b0;
          ovf_q  <= 1'b0;
        end
        S_ACC: begin
          acc_q <= acc_q + ACCW'(op_q[k_q]);
          k_q   <= k_q + KW'(1);
        end
        S_DONE: begin
          result_q <= (SATURATE && acc_hi) ? '1 : acc_q[OP_WIDTH-1:0];
          ovf_q    <= acc_hi;
          done_q   <= 1'b1;
          irq_q    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign s_axi.S_AXI_AWREADY = awready_q;
  assign s_axi.S_AXI_WREADY  = awready_q;
  assign s_axi.S_AXI_BVALID  = bvalid_q;
  assign s_axi.S_AXI_BRESP   = bresp_q;
  assign s_axi.S_AXI_ARREADY = arready_q;
  assign s_axi.S_AXI_RVALID  = rvalid_q;
  assign s_axi.S_AXI_RDATA   = rdata_q;
  assign s_axi.S_AXI_RRESP   = 2'b00;
  assign done_irq            = irq_q;

  // Byte-lane address bits carry no information for word registers.
  logic unused;
  assign unused = ^{s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0]};
endmodule
